chroma_pixel_renderer: RTL

Pixel-side consumer of the chroma control settings. Takes the tone word `ton` and the 3-bit letter and screen colour indices `ColorL`/`ColorP`, and renders every active VGA pixel into an RGB332 byte. Settings are latched only at frame start, so the picture never tears mid-frame. Sits between the character/glyph generator and the VGA DAC pins. It also owns the frame-counted cursor blink.

---
 rtl/chroma_pkg.sv | 35 +++
 rtl/chroma_tone_map.sv | 30 +++
 rtl/chroma_pixel_renderer.sv | 114 +++++++++++
 3 files changed

// File: rtl/chroma_pkg.sv
// Shared chroma definitions: reset values of the chroma settings, tone-word
// field positions, palette bit assignments and the RGB332 pixel payload.
// Used by the chroma control block and by the pixel renderer.
package chroma_pkg;

    localparam int unsigned TON_W = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;

    // Reset values of the chroma settings
    localparam logic [TON_W-1:0] TON_RST    = 8'hA4;
    localparam logic [IDX_W-1:0] COLORL_RST = 3'd0;
    localparam logic [IDX_W-1:0] COLORP_RST = 3'd7;

    // Tone word fields: ton[2:0] red, ton[5:3] green, ton[7:6] blue
    localparam int unsigned R_W       = 3;
    localparam int unsigned G_W       = 3;
    localparam int unsigned B_W       = 2;
    localparam int unsigned TON_R_LSB = 0;
    localparam int unsigned TON_G_LSB = 3;
    localparam int unsigned TON_B_LSB = 6;

    // Palette index bits
    localparam int unsigned PAL_R_BIT = 2;
    localparam int unsigned PAL_G_BIT = 1;
    localparam int unsigned PAL_B_BIT = 0;

    // RGB332 pixel, packs as {R[2:0], G[2:0], B[1:0]}
    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb332_t;

endpackage

// File: rtl/chroma_tone_map.sv
// Combinational palette + tone mapping: 3-bit colour index and 8-bit tone word
// to an RGB332 pixel. A component enabled by the palette never drops below
// level 1, so a zero tone field still leaves the colour visible.
// Ports:
//   idx_i   - palette index (bit2 R, bit1 G, bit0 B)
//   ton_i   - tone word
//   rgb_o_c - mapped RGB332 pixel (combinational)
module chroma_tone_map
    import chroma_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    input  logic [TON_W-1:0] ton_i,
    output rgb332_t          rgb_o_c
);

    logic [R_W-1:0] r_lvl;
    logic [G_W-1:0] g_lvl;
    logic [B_W-1:0] b_lvl;

    always_comb begin
        r_lvl   = ton_i[TON_R_LSB +: R_W];
        g_lvl   = ton_i[TON_G_LSB +: G_W];
        b_lvl   = ton_i[TON_B_LSB +: B_W];
        rgb_o_c = '0;
        if (idx_i[PAL_R_BIT]) rgb_o_c.r = (r_lvl == '0) ? R_W'(1) : r_lvl;
        if (idx_i[PAL_G_BIT]) rgb_o_c.g = (g_lvl == '0) ? G_W'(1) : g_lvl;
        if (idx_i[PAL_B_BIT]) rgb_o_c.b = (b_lvl == '0) ? B_W'(1) : b_lvl;
    end

endmodule

// File: rtl/chroma_pixel_renderer.sv
// Renders active VGA pixels to RGB332 from chroma settings that are latched
// only at frame start (tear-free), and owns the frame-counted cursor blink.
// Two-stage pipeline, 1 pixel/cycle, result 2 cycles after input.
// Ports:
//   Clk, reset         - pixel clock, synchronous active-high reset
//   ton, ColorL/ColorP - tone word, letter / screen colour indices
//   frame_start        - pulse on the first pixel of a frame
//   pix_valid          - active video
//   text_bit           - glyph pixel is a letter pixel
//   cursor_bit         - pixel lies in the cursor cell
//   rgb, rgb_valid     - rendered pixel and its valid flag
//   blink              - current cursor blink phase
module chroma_pixel_renderer
    import chroma_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic [TON_W-1:0] ton,
    input  logic [IDX_W-1:0] ColorL,
    input  logic [IDX_W-1:0] ColorP,
    input  logic             frame_start,
    input  logic             pix_valid,
    input  logic             text_bit,
    input  logic             cursor_bit,
    output logic [7:0]       rgb,
    output logic             rgb_valid,
    output logic             blink
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [TON_W-1:0] ton_s_q, ton_s_d;
    logic [IDX_W-1:0] l_s_q, l_s_d;
    logic [IDX_W-1:0] p_s_q, p_s_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             blink_q, blink_d;

    logic             s1_valid_q, s1_text_q, s1_cursor_q;

    logic [IDX_W-1:0] eff_l;
    logic [IDX_W-1:0] idx;
    logic             fg;
    rgb332_t          map_rgb;
    rgb332_t          rgb_q, rgb_d;
    logic             rgb_valid_q, rgb_valid_d;

    // Frame-start shadow load and blink counter
    always_comb begin
        ton_s_d     = ton_s_q;
        l_s_d       = l_s_q;
        p_s_d       = p_s_q;
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (frame_start) begin
            ton_s_d = ton;
            l_s_d   = ColorL;
            p_s_d   = ColorP;
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end
    end

    // Stage 2: contrast guard, foreground select, tone map, blanking
    always_comb begin
        eff_l       = (l_s_q == p_s_q) ? ~p_s_q : l_s_q;
        fg          = s1_text_q ^ (s1_cursor_q & blink_q);
        idx         = fg ? eff_l : p_s_q;
        rgb_valid_d = s1_valid_q;
        rgb_d       = s1_valid_q ? map_rgb : '0;
    end

    chroma_tone_map u_tone_map (
        .idx_i   (idx),
        .ton_i   (ton_s_q),
        .rgb_o_c (map_rgb)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            ton_s_q     <= TON_RST;
            l_s_q       <= COLORL_RST;
            p_s_q       <= COLORP_RST;
            frame_cnt_q <= '0;
            blink_q     <= 1'b1;
            s1_valid_q  <= 1'b0;
            s1_text_q   <= 1'b0;
            s1_cursor_q <= 1'b0;
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
        end else begin
            ton_s_q     <= ton_s_d;
            l_s_q       <= l_s_d;
            p_s_q       <= p_s_d;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
            s1_valid_q  <= pix_valid;
            s1_text_q   <= text_bit;
            s1_cursor_q <= cursor_bit;
            rgb_q       <= rgb_d;
            rgb_valid_q <= rgb_valid_d;
        end
    end

    assign rgb       = rgb_q;
    assign rgb_valid = rgb_valid_q;
    assign blink     = blink_q;

endmodule
